alu_vec_sequencer: RTL and testbench

Serial stimulus/response driver for the 60-input, 26-output combinational ALU benchmark core. It sits on the input side of the core and drives its 60 primary inputs G1..G60 from a serially loaded vector. After a programmable settle time it captures the core's 26 outputs G855..G880 and shifts them back out serially. It turns the purely combinational netlist into a sequential, pin-light benchmark with a start/done handshake.

---
 rtl/alu_vec_sequencer.sv | 131 +++++++++++++
 tb/tb_alu_vec_sequencer.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_vec_sequencer.sv
// alu_vec_sequencer: serial load / apply / settle / capture / serial unload
// driver that turns a combinational ALU benchmark core into a sequential,
// pin-light block with a start/done handshake.
module alu_vec_sequencer #(
  parameter int STIM_W = 60,
  parameter int RESP_W = 26,
  parameter int SETTLE = 2
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              start,
  input  logic              si,
  input  logic              si_valid,
  output logic [STIM_W-1:0] stim,
  input  logic [RESP_W-1:0] resp,
  output logic              so,
  output logic              so_valid,
  output logic              busy,
  output logic              done,
  output logic              resp_par
);

  localparam int MAX_W  = (STIM_W > RESP_W) ? STIM_W : RESP_W;
  localparam int CNT_W  = $clog2(MAX_W);
  localparam int SCNT_W = 4;  // SETTLE is limited to 1..15

  localparam logic [CNT_W-1:0]  LAST_IN     = CNT_W'(STIM_W - 1);
  localparam logic [CNT_W-1:0]  LAST_OUT    = CNT_W'(RESP_W - 1);
  localparam logic [SCNT_W-1:0] LAST_SETTLE = SCNT_W'(SETTLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT_IN,
    S_APPLY,
    S_SETTLE,
    S_CAPTURE,
    S_SHIFT_OUT,
    S_DONE
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [CNT_W-1:0]    cnt_q;
  logic [SCNT_W-1:0]   scnt_q;
  logic [STIM_W-1:0]   shadow_q;
  logic [RESP_W-1:0]   rsr_q;

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values and the order of statements cannot create races.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic for the load/apply/settle/capture/unload sequence.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start) state_d = S_SHIFT_IN;
      S_SHIFT_IN:  if (si_valid && (cnt_q == LAST_IN)) state_d = S_APPLY;
      S_APPLY:     state_d = S_SETTLE;
      S_SETTLE:    if (scnt_q == LAST_SETTLE) state_d = S_CAPTURE;
      S_CAPTURE:   state_d = S_SHIFT_OUT;
      S_SHIFT_OUT: if (cnt_q == LAST_OUT) state_d = S_DONE;
      S_DONE:      state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  // Datapath and registered outputs; flags are derived from the next state
  // so they line up with the state they describe without a cycle of lag.
  // NOTE: the shadow and response registers are ordinary flops, so they are
  // reset along with everything else; a reset leaves no stale vector behind.
  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      stim     <= '0;
      shadow_q <= '0;
      rsr_q    <= '0;
      cnt_q    <= '0;
      scnt_q   <= '0;
      so       <= 1'b0;
      so_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      resp_par <= 1'b0;
    end else begin
      busy     <= (state_d != S_IDLE);
      done     <= (state_d == S_DONE);
      so_valid <= (state_d == S_SHIFT_OUT);
      case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            shadow_q <= '0;
          end
        end
        S_SHIFT_IN: begin
          // LSB-first load: after STIM_W accepted bits the first one sits in bit 0.
          if (si_valid) begin
            shadow_q <= {si, shadow_q[STIM_W-1:1]};
            if (cnt_q != LAST_IN) cnt_q <= cnt_q + 1'b1;
          end
        end
        S_APPLY: begin
          stim   <= shadow_q;
          scnt_q <= '0;
        end
        S_SETTLE: begin
          scnt_q <= scnt_q + 1'b1;
        end
        S_CAPTURE: begin
          rsr_q    <= resp;
          resp_par <= ^resp;
          so       <= resp[0];
          cnt_q    <= '0;
        end
        S_SHIFT_OUT: begin
          // Zeros shift in from the top, so so falls to 0 after the last bit.
          rsr_q <= rsr_q >> 1;
          so    <= rsr_q[1];
          if (cnt_q != LAST_OUT) cnt_q <= cnt_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_vec_sequencer.sv
// tb_alu_vec_sequencer: directed sequence of transactions against three
// builds (SETTLE = 2, 1, 15) sharing the same stimulus, checked against a
// transaction-level reference of the edge-numbered timeline.
`timescale 1ns/1ps
module tb_alu_vec_sequencer;

  localparam int STIM_W = 60;
  localparam int RESP_W = 26;

  logic              CK = 1'b0;
  logic              RST;
  logic              start;
  logic              si;
  logic              si_valid;
  logic [RESP_W-1:0] resp;

  logic [STIM_W-1:0] stim_s2, stim_s1, stim_s15;
  logic so_s2, so_s1, so_s15;
  logic so_valid_s2, so_valid_s1, so_valid_s15;
  logic busy_s2, busy_s1, busy_s15;
  logic done_s2, done_s1, done_s15;
  logic resp_par_s2, resp_par_s1, resp_par_s15;

  int n_tests = 0;
  int n_fail  = 0;
  int rel     = 0;                 // edges since the start edge E0
  logic [STIM_W-1:0] prev_stim;    // vector the model believes is applied
  logic [RESP_W-1:0] tab[$];       // resp value driven before each edge

  int settle_v[];
  int cap[];
  int first_sv[];
  int sv_cnt[];
  int done_edge[];
  int done_cnt[];
  logic [RESP_W-1:0] got[];

  always #5 CK = ~CK;

  alu_vec_sequencer #(.STIM_W(STIM_W), .RESP_W(RESP_W), .SETTLE(2)) u_dut_s2 (
    .CK(CK), .RST(RST), .start(start), .si(si), .si_valid(si_valid),
    .stim(stim_s2), .resp(resp), .so(so_s2), .so_valid(so_valid_s2),
    .busy(busy_s2), .done(done_s2), .resp_par(resp_par_s2)
  );

  alu_vec_sequencer #(.STIM_W(STIM_W), .RESP_W(RESP_W), .SETTLE(1)) u_dut_s1 (
    .CK(CK), .RST(RST), .start(start), .si(si), .si_valid(si_valid),
    .stim(stim_s1), .resp(resp), .so(so_s1), .so_valid(so_valid_s1),
    .busy(busy_s1), .done(done_s1), .resp_par(resp_par_s1)
  );

  alu_vec_sequencer #(.STIM_W(STIM_W), .RESP_W(RESP_W), .SETTLE(15)) u_dut_s15 (
    .CK(CK), .RST(RST), .start(start), .si(si), .si_valid(si_valid),
    .stim(stim_s15), .resp(resp), .so(so_s15), .so_valid(so_valid_s15),
    .busy(busy_s15), .done(done_s15), .resp_par(resp_par_s15)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CK);
    #1;
    rel++;
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_stim_s2"},  64'(stim_s2),  64'(0));
    check({tag, "_stim_s1"},  64'(stim_s1),  64'(0));
    check({tag, "_stim_s15"}, 64'(stim_s15), 64'(0));
    check({tag, "_flags_s2"},
          64'({so_s2, so_valid_s2, busy_s2, done_s2, resp_par_s2}), 64'(0));
    check({tag, "_flags_s1"},
          64'({so_s1, so_valid_s1, busy_s1, done_s1, resp_par_s1}), 64'(0));
    check({tag, "_flags_s15"},
          64'({so_s15, so_valid_s15, busy_s15, done_s15, resp_par_s15}), 64'(0));
  endtask

  // Record one cycle of a build's outputs and check its stim.
  task automatic observe(input int d, input logic sv, input logic sbit, input logic dn,
                         input logic [STIM_W-1:0] st, input logic [STIM_W-1:0] exp_st);
    if (sv) begin
      if (first_sv[d] < 0) first_sv[d] = rel;
      got[d] = {sbit, got[d][RESP_W-1:1]};
      sv_cnt[d]++;
    end
    if (dn) begin
      if (done_edge[d] < 0) done_edge[d] = rel;
      done_cnt[d]++;
    end
    check($sformatf("stim_s%0d_e%0d", settle_v[d], rel), 64'(st), 64'(exp_st));
  endtask

  // Compare one build's transaction against the model.
  task automatic verify(input int d, input logic par);
    string s;
    s = $sformatf("_s%0d", settle_v[d]);
    check({"so_valid_first", s}, 64'(first_sv[d]), 64'(cap[d]));
    check({"so_valid_len", s},   64'(sv_cnt[d]),   64'(RESP_W));
    check({"so_stream", s},      64'(got[d]),      64'(tab[cap[d]]));
    check({"done_edge", s},      64'(done_edge[d]), 64'(cap[d] + RESP_W));
    check({"done_pulses", s},    64'(done_cnt[d]), 64'(1));
    check({"resp_par", s},       64'(par),         64'(^tab[cap[d]]));
  endtask

  // One transaction: start at E0, LSB-first load (optionally stalling every
  // other cycle), then random resp/si traffic while the builds finish.
  task automatic run_txn(input logic [STIM_W-1:0] vec, input bit stall,
                         input bit const_mode, input logic [RESP_W-1:0] const_val,
                         input bit pulse, input bit hold, input int abort_off,
                         output int done0, output int stalls);
    int k;
    int apply;
    int end_rel;
    bit aborted;
    logic [STIM_W-1:0] vec_sh;
    vec_sh  = vec;
    stalls  = 0;
    k       = 0;
    aborted = 1'b0;
    for (int d = 0; d < 3; d++) begin
      first_sv[d]  = -1;
      sv_cnt[d]    = 0;
      done_edge[d] = -1;
      done_cnt[d]  = 0;
      got[d]       = '0;
    end
    start    = 1'b1;
    si_valid = 1'b0;
    @(posedge CK);
    #1;
    rel   = 0;
    start = hold;
    while (k < STIM_W) begin
      if (stall && (rel % 2 == 0)) begin
        si_valid = 1'b0;
        si       = 1'($urandom);
        stalls++;
      end else begin
        si_valid = 1'b1;
        si       = vec_sh[0];
      end
      step();
      if (si_valid) begin
        k++;
        vec_sh = vec_sh >> 1;
      end
      check("stim_hold_s2",  64'(stim_s2),  64'(prev_stim));
      check("stim_hold_s15", 64'(stim_s15), 64'(prev_stim));
      check("busy_shift_in", 64'(busy_s2),  64'(1));
    end
    apply = rel + 1;
    for (int d = 0; d < 3; d++) cap[d] = apply + settle_v[d] + 1;
    tab.delete();
    for (int n = 0; n < 256; n++)
      tab.push_back((const_mode && n <= cap[0]) ? const_val : RESP_W'($urandom));
    end_rel = cap[2] + RESP_W + 2;
    while (rel < end_rel && !aborted) begin
      resp     = tab[rel + 1];
      si       = 1'($urandom);
      si_valid = 1'($urandom);
      start    = hold || (pulse && ((rel + 1 == apply + 2) || (rel + 1 == cap[0] + 5)));
      if (abort_off >= 0 && rel == cap[0] + abort_off) begin
        check("so_valid_before_abort", 64'(so_valid_s2), 64'(1));
        #2 RST = 1'b1;
        #1 reset_check("abort");
        #1 RST = 1'b0;
        aborted   = 1'b1;
        prev_stim = '0;
      end else begin
        step();
        observe(0, so_valid_s2,  so_s2,  done_s2,  stim_s2,  (rel >= apply) ? vec : prev_stim);
        observe(1, so_valid_s1,  so_s1,  done_s1,  stim_s1,  (rel >= apply) ? vec : prev_stim);
        observe(2, so_valid_s15, so_s15, done_s15, stim_s15, (rel >= apply) ? vec : prev_stim);
        if (hold)
          check($sformatf("busy_hold_e%0d", rel), 64'(busy_s2),
                64'(rel != cap[0] + RESP_W + 1));
        else
          check($sformatf("busy_e%0d", rel), 64'(busy_s2), 64'(rel <= cap[0] + RESP_W));
      end
    end
    if (!aborted) begin
      verify(0, resp_par_s2);
      verify(1, resp_par_s1);
      verify(2, resp_par_s15);
      prev_stim = vec;
    end
    start    = 1'b0;
    si_valid = 1'b0;
    done0    = done_edge[0];
  endtask

  initial begin
    int d0;
    int st;
    logic [STIM_W-1:0] v;
    settle_v    = new[3];
    settle_v[0] = 2;
    settle_v[1] = 1;
    settle_v[2] = 15;
    cap       = new[3];
    first_sv  = new[3];
    sv_cnt    = new[3];
    done_edge = new[3];
    done_cnt  = new[3];
    got       = new[3];

    RST       = 1'b1;
    start     = 1'b0;
    si        = 1'b0;
    si_valid  = 1'b0;
    resp      = '0;
    prev_stim = '0;
    #3 reset_check("por");
    repeat (2) @(posedge CK);
    #1 RST = 1'b0;
    step();
    check("idle_busy", 64'(busy_s2), 64'(0));

    // Alternating response, no stalls: done after E90, odd parity.
    run_txn(60'h0FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 26'h2AA_AAAA, 1'b0, 1'b0, -1, d0, st);
    check("done_edge_default", 64'(d0), 64'(90));
    check("resp_par_alt", 64'(resp_par_s2), 64'(1));

    // Random vector and response with start pulsed during SETTLE and SHIFT_OUT.
    v = STIM_W'({$urandom, $urandom});
    run_txn(v, 1'b0, 1'b0, '0, 1'b1, 1'b0, -1, d0, st);

    // Same load as the first, stalling every other cycle.
    run_txn(60'h0FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 26'h2AA_AAAA, 1'b0, 1'b0, -1, d0, st);
    check("done_edge_stalled", 64'(d0), 64'(90 + st));

    // Reset ten cycles into SHIFT_OUT, then confirm nothing resumes.
    v = STIM_W'({$urandom, $urandom});
    run_txn(v, 1'b0, 1'b0, '0, 1'b0, 1'b0, 10, d0, st);
    repeat (3) begin
      step();
      check("no_done_after_abort", 64'({done_s2, done_s1, done_s15}), 64'(0));
      check("idle_after_abort", 64'({busy_s2, busy_s1, busy_s15}), 64'(0));
    end

    // A normal transaction after the abort.
    v = STIM_W'({$urandom, $urandom});
    run_txn(v, 1'b0, 1'b0, '0, 1'b0, 1'b0, -1, d0, st);

    // start held high: back-to-back with a single idle cycle.
    v = STIM_W'({$urandom, $urandom});
    run_txn(v, 1'b0, 1'b0, '0, 1'b0, 1'b1, -1, d0, st);

    #2 RST = 1'b1;
    #1 reset_check("final");
    RST = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
